// File: rtl/opn_sel_pkg.sv
// opn_sel_pkg
// Shared definitions for the output polarity selector:
//   - 2-bit channel mode encodings (OFF / PASS / INV / HOLD)
//   - per-channel FSM state encoding
//   - dead-time counter width helper
//   - mode -> output bit helper used by every channel
package opn_sel_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_PASS = 2'b01;
  localparam logic [1:0] MODE_INV  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } ch_state_t;

  // Counter must hold DEAD-1; keep at least one bit so the vector is legal
  // even when dead time is disabled.
  function automatic int cnt_width(input int dead);
    if (dead < 1) return 1;
    return $clog2(dead + 1);
  endfunction

  // Output bit produced by a mode given the synchronised source and the
  // value currently on the pin (HOLD simply keeps it).
  function automatic logic mode_out(input logic [1:0] mode, input logic din,
                                    input logic held);
    case (mode)
      MODE_PASS: return din;
      MODE_INV:  return ~din;
      MODE_HOLD: return held;
      default:   return 1'b0;
    endcase
  endfunction

  // Settled state for a mode once no dead time is pending.
  function automatic ch_state_t run_state(input logic [1:0] mode);
    return (mode == MODE_OFF) ? S_OFF : S_RUN;
  endfunction

endpackage

// File: rtl/opn_sel_ch.sv
// opn_sel_ch
// One output channel: input synchroniser, double-buffered mode (pend/cur),
// break-before-make dead-time FSM and registered output.
// Ports:
//   clock, reset  - clock and asynchronous active-high reset
//   sin           - source bit from the waveform core
//   sel, sel_load - requested mode and its load strobe (into pend)
//   sout          - registered channel output
//   busy          - high while the channel is inside dead time
module opn_sel_ch
  import opn_sel_pkg::*;
#(
  parameter int DEAD = 2,
  parameter int SYNC = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sin,
  input  logic [1:0] sel,
  input  logic       sel_load,
  output logic       sout,
  output logic       busy
);

  localparam int             CW        = cnt_width(DEAD);
  localparam bit             HAS_DEAD  = (DEAD > 0);
  localparam logic [CW-1:0]  DEAD_LOAD = HAS_DEAD ? CW'(DEAD - 1) : '0;

  logic synced;

  generate
    if (SYNC == 0) begin : g_nosync
      assign synced = sin;
    end else begin : g_sync
      logic [SYNC-1:0] sync_q;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= sin;
          for (int k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign synced = sync_q[SYNC-1];
    end
  endgenerate

  logic [1:0] pend;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         pend <= MODE_OFF;
    else if (sel_load) pend <= sel;
  end

  ch_state_t     state;
  logic [1:0]    cur;
  logic [CW-1:0] cnt;
  logic          out_q;
  logic          busy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_OFF;
      cur    <= MODE_OFF;
      cnt    <= '0;
      out_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        S_DEAD: begin
          // The schedule is fixed at entry; pend may change freely meanwhile
          // and whatever it holds at expiry becomes the new mode.
          if (cnt == '0) begin
            cur    <= pend;
            state  <= run_state(pend);
            busy_q <= 1'b0;
            out_q  <= mode_out(pend, synced, out_q);
          end else begin
            cnt   <= cnt - CW'(1);
            out_q <= 1'b0;
          end
        end
        default: begin
          if (pend != cur) begin
            if (HAS_DEAD && (pend == MODE_PASS || pend == MODE_INV)) begin
              // Break before make: force the pin low before driving data.
              state  <= S_DEAD;
              cnt    <= DEAD_LOAD;
              busy_q <= 1'b1;
              out_q  <= 1'b0;
            end else begin
              cur   <= pend;
              state <= run_state(pend);
              out_q <= mode_out(pend, synced, out_q);
            end
          end else begin
            out_q <= mode_out(cur, synced, out_q);
          end
        end
      endcase
    end
  end

  assign sout = out_q;
  assign busy = busy_q;

endmodule

// File: rtl/opn_sel_multi.sv
// opn_sel_multi
// Multi-channel output polarity selector placed between the waveform core
// and the external pins. Slices the packed mode bus and instantiates one
// independent channel per output; the load strobe is shared.
// Ports:
//   Clock, Reset - clock and asynchronous active-high reset
//   Sin          - per-channel source bits
//   Sel          - per-channel mode, channel i at [2i+1:2i] ({H,L})
//   Sel_Load     - captures all Sel fields into the pending modes
//   Sout_EXT     - registered channel outputs
//   Busy         - per-channel dead-time indicator
module opn_sel_multi #(
  parameter int CH   = 4,
  parameter int DEAD = 2,
  parameter int SYNC = 2
) (
  input  logic [0:0]      Clock,
  input  logic            Reset,
  input  logic [CH-1:0]   Sin,
  input  logic [2*CH-1:0] Sel,
  input  logic            Sel_Load,
  output logic [CH-1:0]   Sout_EXT,
  output logic [CH-1:0]   Busy
);

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      opn_sel_ch #(
        .DEAD(DEAD),
        .SYNC(SYNC)
      ) u_ch (
        .clock   (Clock[0]),
        .reset   (Reset),
        .sin     (Sin[gi]),
        .sel     (Sel[2*gi+1 -: 2]),
        .sel_load(Sel_Load),
        .sout    (Sout_EXT[gi]),
        .busy    (Busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_opn_sel_multi.sv
// Directed bench for opn_sel_multi: a default build (CH=4, DEAD=2, SYNC=2)
// and a DEAD=0/SYNC=0 build share the same inputs.
module tb_opn_sel_multi;

  logic       Clock;
  logic       Reset;
  logic [3:0] Sin;
  logic [7:0] Sel;
  logic       Sel_Load;
  logic [3:0] sout;
  logic [3:0] busy;
  logic [3:0] sout0;
  logic [3:0] busy0;

  int total = 0;
  int bad   = 0;

  opn_sel_multi #(.CH(4), .DEAD(2), .SYNC(2)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Sin     (Sin),
    .Sel     (Sel),
    .Sel_Load(Sel_Load),
    .Sout_EXT(sout),
    .Busy    (busy)
  );

  opn_sel_multi #(.CH(4), .DEAD(0), .SYNC(0)) dut0 (
    .Clock   (Clock),
    .Reset   (Reset),
    .Sin     (Sin),
    .Sel     (Sel),
    .Sel_Load(Sel_Load),
    .Sout_EXT(sout0),
    .Busy    (busy0)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    Sin      = 4'b0000;
    Sel      = 8'h00;
    Sel_Load = 1'b0;
    tick(3);
    Reset = 1'b0;
    tick(2);
    chk("reset_sout", sout, 4'b0000);
    chk("reset_busy", busy, 4'b0000);
    chk("reset_sout0", sout0, 4'b0000);
    chk("reset_busy0", busy0, 4'b0000);

    // ch0 OFF -> PASS through dead time
    Sin = 4'b0001;
    tick(3);
    Sel = 8'h01; Sel_Load = 1'b1;
    tick();                                   // edge t
    Sel_Load = 1'b0;
    chk("pass_t_busy", busy, 4'b0000);
    chk("pass_t_sout", sout, 4'b0000);
    tick();                                   // t+1
    chk("pass_t1_busy", busy, 4'b0001);
    chk("pass_t1_sout", sout, 4'b0000);
    tick();                                   // t+2
    chk("pass_t2_busy", busy, 4'b0001);
    chk("pass_t2_sout", sout, 4'b0000);
    tick();                                   // t+3
    chk("pass_t3_busy", busy, 4'b0000);
    chk("pass_t3_sout", sout, 4'b0001);

    // data latency SYNC+1 = 3 edges
    Sin = 4'b0000;
    tick();
    chk("lat_e1", sout, 4'b0001);
    tick();
    chk("lat_e2", sout, 4'b0001);
    tick();
    chk("lat_e3", sout, 4'b0000);

    // PASS -> INV with Sin[0]=1
    Sin = 4'b0001;
    tick(3);
    chk("inv_pre", sout, 4'b0001);
    Sel = 8'h02; Sel_Load = 1'b1;
    tick();
    Sel_Load = 1'b0;
    chk("inv_t", sout, 4'b0001);
    tick();
    chk("inv_t1_sout", sout, 4'b0000);
    chk("inv_t1_busy", busy, 4'b0001);
    tick();
    chk("inv_t2_busy", busy, 4'b0001);
    tick();
    chk("inv_t3_sout", sout, 4'b0000);
    chk("inv_t3_busy", busy, 4'b0000);

    // INV -> PASS
    Sel = 8'h01; Sel_Load = 1'b1;
    tick();
    Sel_Load = 1'b0;
    chk("ret_t", sout, 4'b0000);
    tick();
    chk("ret_t1_busy", busy, 4'b0001);
    tick();
    chk("ret_t2_sout", sout, 4'b0000);
    tick();
    chk("ret_t3_sout", sout, 4'b0001);
    chk("ret_t3_busy", busy, 4'b0000);

    // ch1 PASS, then HOLD, then OFF
    Sin = 4'b0011;
    Sel = 8'h05; Sel_Load = 1'b1;
    tick();
    Sel_Load = 1'b0;
    tick();
    chk("ch1_t1_busy", busy, 4'b0010);
    tick(2);
    chk("ch1_t3_sout", sout, 4'b0011);
    chk("ch1_t3_busy", busy, 4'b0000);
    Sel = 8'h0D; Sel_Load = 1'b1;
    tick();
    Sel_Load = 1'b0;
    tick();
    chk("hold_t1_sout", sout, 4'b0011);
    chk("hold_t1_busy", busy, 4'b0000);
    Sin = 4'b0001;
    tick(4);
    chk("hold_frozen_sout", sout, 4'b0011);
    chk("hold_frozen_busy", busy, 4'b0000);
    Sel = 8'h01; Sel_Load = 1'b1;
    tick();
    Sel_Load = 1'b0;
    chk("off_t_sout", sout, 4'b0011);
    tick();
    chk("off_t1_sout", sout, 4'b0001);
    chk("off_t1_busy", busy, 4'b0000);

    // ch2 reloads during dead time: 01, then 10, then 01 on consecutive edges
    Sin = 4'b0101;
    tick(3);
    Sel = 8'h11; Sel_Load = 1'b1;
    tick();                                   // t
    Sel = 8'h21;
    tick();                                   // t+1
    chk("dr_t1_busy", busy, 4'b0100);
    Sel = 8'h11;
    tick();                                   // t+2
    chk("dr_t2_busy", busy, 4'b0100);
    chk("dr_t2_sout", sout, 4'b0001);
    Sel_Load = 1'b0;
    Sel = 8'h21;
    tick();                                   // t+3
    chk("dr_t3_busy", busy, 4'b0000);
    chk("dr_t3_sout", sout, 4'b0101);
    tick(2);
    chk("noload_sout", sout, 4'b0101);
    chk("noload_busy", busy, 4'b0000);

    // async reset in the middle of ch3 dead time
    Sin = 4'b1101;
    Sel = 8'h51; Sel_Load = 1'b1;
    tick();
    Sel_Load = 1'b0;
    tick();
    chk("rst_pre_busy", busy, 4'b1000);
    Reset = 1'b1;
    #1;
    chk("rst_async_sout", sout, 4'b0000);
    chk("rst_async_busy", busy, 4'b0000);
    tick(2);
    Reset = 1'b0;
    tick(4);
    chk("rst_after_sout", sout, 4'b0000);
    chk("rst_after_busy", busy, 4'b0000);

    // DEAD=0, SYNC=0 build
    Sin = 4'b0001;
    Sel = 8'h01; Sel_Load = 1'b1;
    tick();
    Sel_Load = 1'b0;
    chk("d0_t_sout", sout0, 4'b0000);
    tick();
    chk("d0_t1_sout", sout0, 4'b0001);
    chk("d0_t1_busy", busy0, 4'b0000);
    Sin = 4'b0000;
    tick();
    chk("d0_lat_lo", sout0, 4'b0000);
    Sin = 4'b0001;
    tick();
    chk("d0_lat_hi", sout0, 4'b0001);
    Sel = 8'h02; Sel_Load = 1'b1; Sin = 4'b0000;
    tick();
    Sel_Load = 1'b0;
    chk("d0_inv_t", sout0, 4'b0000);
    tick();
    chk("d0_inv_t1", sout0, 4'b0001);
    chk("d0_inv_busy", busy0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
